// File: rtl/uart_defs_pkg.sv
// ---------------------------------------------------------------------------
// uart_defs_pkg
// Shared constants and types for the starter-board UART (transmitter and
// receiver). Holds the framing constants for 8N1, the default bit period for
// a 50 MHz clock at 115200 baud, and the serial FSM state encoding.
// ---------------------------------------------------------------------------
package uart_defs_pkg;

    // 8N1 framing: one start bit, eight data bits, one stop bit.
    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    // 50_000_000 / 115_200 rounds to 434 clocks per serial bit.
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    // Serial line state machine, shared by the transmitter and receiver.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// ---------------------------------------------------------------------------
// uart_bit_timer
// Baud-period counter. Counts 0..CLKS_PER_BIT-1 and flags the final cycle of
// each bit period. A restart clears the count so that bit timing is aligned
// to the start of each frame and never drifts across frames.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - synchronous active-high reset, clears the count
//   restart  - clear the count at this edge (held high while idle)
//   bit_done - high during the last cycle of a bit period
// ---------------------------------------------------------------------------
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic bit_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // bit_done is decoded from the count alone (not from restart) so the
    // parent can use it to decide whether to restart without forming a loop.
    // With CLKS_PER_BIT >= 2 the terminal count is never 0, so a count held
    // at 0 during idle never produces a spurious bit_done.
    always_comb begin
        bit_done = (cnt_q == LAST_CNT);
        cnt_d    = cnt_q + CNT_W'(1);
        if (restart || bit_done) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// 8N1 serial transmitter with a one-entry holding register in front of the
// shift register, so a byte written while a frame is on the line is sent
// immediately after the current stop bit with no idle gap.
//
// Ports:
//   clk     - system clock, rising edge
//   reset   - synchronous active-high reset; aborts any frame in progress
//   tx_data - byte to send, sampled when a write is accepted
//   tx_wr   - write strobe; accepted at an edge where tx_flag is high
//   tx_flag - registered; 1 = holding register empty
//   txd     - registered serial output, idle high
//   busy    - registered; 1 from start bit through stop bit
// ---------------------------------------------------------------------------
module uart_tx
    import uart_defs_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_wr,
    output logic                 tx_flag,
    output logic                 txd,
    output logic                 busy
);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic                 txd_q, txd_d;
    logic                 busy_q, busy_d;
    logic                 tx_flag_q, tx_flag_d;

    logic accept;
    logic transfer;
    logic restart;
    logic bit_done;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .bit_done(bit_done)
    );

    // A write and a transfer can never coincide: tx_flag is low exactly
    // when the holding register is full, and transfers need it full.
    // The timer is held cleared while idle and cleared again on each
    // transfer so every frame starts with a fresh bit period.
    always_comb begin
        accept   = tx_wr && tx_flag_q;
        transfer = hold_full_q &&
                   ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_done));
        restart  = transfer || (state_q == ST_IDLE);
    end

    // Holding register; tx_flag is the registered inverse of its full bit.
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (accept) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end else if (transfer) begin
            hold_full_d = 1'b0;
        end
        tx_flag_d = !hold_full_d;
    end

    // Shifter and bit counter. The shifter is not advanced on the
    // START->DATA edge, so bit 0 is presented first; it shifts right at the
    // end of each data bit. The 3-bit counter wraps naturally after bit 7.
    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        if (transfer) begin
            shift_d   = hold_q;
            bit_cnt_d = '0;
        end else if ((state_q == ST_DATA) && bit_done) begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 3'd1;
        end
    end

    // Next-state logic. STOP goes straight back to START when a byte is
    // waiting, which is what gives back-to-back frames with no gap.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (transfer) state_d = ST_START;
            end
            ST_START: begin
                if (bit_done) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_done && (bit_cnt_q == 3'd7)) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (transfer)      state_d = ST_START;
                else if (bit_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the next state so txd and busy come straight from
    // flops and change on the same edge as the state.
    always_comb begin
        txd_d  = 1'b1;
        busy_d = 1'b1;
        unique case (state_d)
            ST_IDLE:  busy_d = 1'b0;
            ST_START: txd_d  = 1'b0;
            ST_DATA:  txd_d  = shift_d[0];
            ST_STOP:  txd_d  = 1'b1;
            default:  busy_d = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers. Reset drops any frame in progress and
    // empties the holding register.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            txd_q       <= 1'b1;
            busy_q      <= 1'b0;
            tx_flag_q   <= 1'b1;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            txd_q       <= txd_d;
            busy_q      <= busy_d;
            tx_flag_q   <= tx_flag_d;
        end
    end

    assign txd     = txd_q;
    assign busy    = busy_q;
    assign tx_flag = tx_flag_q;

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
// Self-checking bench for uart_tx. A fast instance (4 clocks per bit) covers
// framing, handshake, back-to-back and reset behaviour; a second instance at
// the default 434 clocks per bit checks real bit timing. Accepted bytes go
// into a scoreboard queue and a line monitor decodes frames and pops them.
// ---------------------------------------------------------------------------
module tb_uart_tx;

    localparam int CPB      = 4;
    localparam int CPB_SLOW = 434;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_wr = 1'b0;
    logic       tx_flag, txd, busy;

    logic [7:0] tx_data2 = 8'h00;
    logic       tx_wr2 = 1'b0;
    logic       tx_flag2, txd2, busy2;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int frames_seen = 0;
    bit mon_en = 1'b1;
    logic [7:0] sb[$];

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs[5];

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk    (clk),
        .reset  (reset),
        .tx_data(tx_data),
        .tx_wr  (tx_wr),
        .tx_flag(tx_flag),
        .txd    (txd),
        .busy   (busy)
    );

    uart_tx #(.CLKS_PER_BIT(CPB_SLOW)) dut_slow (
        .clk    (clk),
        .reset  (reset),
        .tx_data(tx_data2),
        .tx_wr  (tx_wr2),
        .tx_flag(tx_flag2),
        .txd    (txd2),
        .busy   (busy2)
    );

    // 10 ns clock; cyc counts rising edges for interval measurements.
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Safety net so the run always ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
        end
    endtask

    // Called at a falling edge: drives one write strobe for one cycle and
    // returns at the next falling edge. The bench's own expectation of
    // acceptance decides whether the byte enters the scoreboard.
    task automatic applyStimulus(input logic [7:0] d, input bit expect_accept);
        checkOutput("wr_flag_before", {15'd0, tx_flag}, {15'd0, expect_accept});
        tx_data = d;
        tx_wr   = 1'b1;
        if (expect_accept) sb.push_back(d);
        @(negedge clk);
        tx_wr = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        bit found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (!busy && tx_flag) found = 1'b1;
            else @(negedge clk);
        end
        checkOutput(name, {15'd0, found}, 16'd1);
        repeat (3) @(negedge clk);
    endtask

    // Line monitor: finds a start bit, samples each bit mid-period and
    // compares the decoded byte with the oldest scoreboard entry.
    initial begin : line_monitor
        logic       prev;
        logic [7:0] b;
        logic [7:0] expb;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && !reset && prev && !txd) begin
                repeat (CPB / 2) @(negedge clk);
                checkOutput("mon_start_bit", {15'd0, txd}, 16'd0);
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) @(negedge clk);
                    b[k] = txd;
                end
                repeat (CPB) @(negedge clk);
                checkOutput("mon_stop_bit", {15'd0, txd}, 16'd1);
                frames_seen++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL mon_unexpected_frame: got %0h want none", b);
                end else begin
                    expb = sb.pop_front();
                    checkOutput("mon_byte", {8'd0, b}, {8'd0, expb});
                end
                prev = txd;
            end else begin
                prev = txd;
            end
        end
    end

    initial begin : main
        logic [9:0] lvl;
        bit         found;
        int         t1;
        int         errs;
        int         busy_errs;

        vecs[0] = '{data: 8'h55, frame: 10'h2AA};
        vecs[1] = '{data: 8'h00, frame: 10'h200};
        vecs[2] = '{data: 8'hFF, frame: 10'h3FE};
        vecs[3] = '{data: 8'h96, frame: 10'h32C};
        vecs[4] = '{data: 8'h01, frame: 10'h202};

        // Reset, then 50 idle cycles.
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checkOutput("idle_txd", {15'd0, txd}, 16'd1);
            checkOutput("idle_flag", {15'd0, tx_flag}, 16'd1);
            checkOutput("idle_busy", {15'd0, busy}, 16'd0);
        end

        // Single bytes into an idle transmitter, checked cycle by cycle.
        for (int v = 0; v < 5; v++) begin
            lvl = vecs[v].frame;
            applyStimulus(vecs[v].data, 1'b1);
            checkOutput("lat_flag_low", {15'd0, tx_flag}, 16'd0);
            checkOutput("lat_txd_high", {15'd0, txd}, 16'd1);
            checkOutput("lat_busy_low", {15'd0, busy}, 16'd0);
            for (int c = 0; c < 10 * CPB; c++) begin
                @(negedge clk);
                if (c == 0) checkOutput("lat_flag_back", {15'd0, tx_flag}, 16'd1);
                checkOutput("frame_txd", {15'd0, txd}, {15'd0, lvl[c / CPB]});
                checkOutput("frame_busy", {15'd0, busy}, 16'd1);
            end
            @(negedge clk);
            checkOutput("frame_end_busy", {15'd0, busy}, 16'd0);
            checkOutput("frame_end_txd", {15'd0, txd}, 16'd1);
            repeat (3) @(negedge clk);
        end

        // Back-to-back: 0xA5 then 0x3C as soon as the slot frees.
        applyStimulus(8'hA5, 1'b1);
        checkOutput("b2b_flag_low", {15'd0, tx_flag}, 16'd0);
        @(negedge clk);
        checkOutput("b2b_start1", {15'd0, txd}, 16'd0);
        t1 = cyc;
        applyStimulus(8'h3C, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (tx_flag) found = 1'b1;
            else @(negedge clk);
        end
        checkOutput("b2b_flag_return", {15'd0, found}, 16'd1);
        checkOutput("b2b_spacing", 16'(cyc - t1), 16'(10 * CPB));
        checkOutput("b2b_start2", {15'd0, txd}, 16'd0);
        checkOutput("b2b_busy", {15'd0, busy}, 16'd1);
        waitIdle("b2b_idle_timeout");

        // Third write while the holding register is full is dropped.
        applyStimulus(8'h11, 1'b1);
        @(negedge clk);
        applyStimulus(8'h22, 1'b1);
        applyStimulus(8'h33, 1'b0);
        checkOutput("drop_flag_low", {15'd0, tx_flag}, 16'd0);
        waitIdle("drop_idle_timeout");

        // Reset during bit 3 of a 0xF0 frame.
        mon_en = 1'b0;
        applyStimulus(8'hF0, 1'b1);
        repeat (1 + CPB + 3 * CPB + 1) @(negedge clk);
        checkOutput("rst_mid_busy", {15'd0, busy}, 16'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        checkOutput("rst_txd", {15'd0, txd}, 16'd1);
        checkOutput("rst_flag", {15'd0, tx_flag}, 16'd1);
        checkOutput("rst_busy", {15'd0, busy}, 16'd0);
        errs = 0;
        for (int i = 0; i < 12 * CPB; i++) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) errs++;
        end
        checkOutput("rst_line_quiet", 16'(errs), 16'd0);
        mon_en = 1'b1;
        @(negedge clk);
        applyStimulus(8'h81, 1'b1);
        waitIdle("rst_after_idle_timeout");

        checkOutput("sb_empty", 16'(sb.size()), 16'd0);
        checkOutput("frames_seen", 16'(frames_seen), 16'd10);

        // Full-rate timing at 434 clocks per bit, byte 0x0D.
        lvl = 10'b1000011010;
        tx_data2 = 8'h0D;
        tx_wr2   = 1'b1;
        @(negedge clk);
        tx_wr2 = 1'b0;
        checkOutput("slow_flag_low", {15'd0, tx_flag2}, 16'd0);
        @(negedge clk);
        busy_errs = 0;
        for (int b = 0; b < 10; b++) begin
            errs = 0;
            for (int j = 0; j < CPB_SLOW; j++) begin
                if (txd2 !== lvl[b]) errs++;
                if (busy2 !== 1'b1) busy_errs++;
                @(negedge clk);
            end
            checkOutput($sformatf("slow_bit%0d", b), 16'(errs), 16'd0);
        end
        checkOutput("slow_busy_span", 16'(busy_errs), 16'd0);
        checkOutput("slow_end_busy", {15'd0, busy2}, 16'd0);
        checkOutput("slow_end_txd", {15'd0, txd2}, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
